// File: rtl/time_disp_pkg.sv
// Shared definitions for the multiplexed BCD time display.
// Font, field encoding and scan-index sizing.
package time_disp_pkg;

  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = 3'd5;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic [1:0] {
    FLD_NONE = 2'd0,
    FLD_HR   = 2'd1,
    FLD_MIN  = 2'd2,
    FLD_SEC  = 2'd3
  } fld_e;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
    fld_e       sel;
  } snap_t;

  function automatic fld_e fld_of_idx(
    input logic [IDX_W-1:0] idx
  );
    fld_e f;
    case (idx)
      3'd0, 3'd1: f = FLD_SEC;
      3'd2, 3'd3: f = FLD_MIN;
      3'd4, 3'd5: f = FLD_HR;
      default:    f = FLD_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Nibble to active-low 7-segment pattern.
// Non-decimal nibbles render as a dash.
module bcd_to_7seg
  import time_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    case (nib)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_time_scan_display.sv
// Six-digit HH.MM.SS scanner with per-frame snapshot,
// leading-zero blanking and field blink.
module bcd_time_scan_display
  import time_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  input  logic [1:0] blink_sel,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]    presc;
  logic [IDX_W-1:0] idx;
  logic [BW-1:0]    bcnt;
  logic             phase;
  snap_t            snap;
  snap_t            cur;
  snap_t            view;

  logic frame_start;
  logic presc_last;
  logic frame_end;

  assign cur = '{hh: hh, mm: mm, ss: ss,
                 pm: pm, sel: fld_e'(blink_sel)};

  assign presc_last  = (presc == P_LAST);
  assign frame_start = (presc == '0) && (idx == '0);
  assign frame_end   = presc_last && (idx == IDX_LAST);

  // The capture cycle already shows the new value
  assign view = frame_start ? cur : snap;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
      bcnt  <= '0;
      phase <= 1'b0;
      snap  <= '0;
    end else begin
      presc <= presc_last ? '0 : presc + PW'(1);
      if (presc_last)
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      if (frame_end) begin
        if (bcnt == B_LAST) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + BW'(1);
        end
      end
      if (frame_start)
        snap <= view;
    end
  end

  logic [3:0] nib;
  logic [6:0] font;
  logic       blank;
  logic       lz;
  logic [6:0] seg_d;
  logic       dp_d;
  logic [5:0] an_d;

  bcd_to_7seg u_dec (
    .nib   (nib),
    .seg_n (font)
  );

  always_comb begin
    nib = '0;
    case (idx)
      3'd0:    nib = view.ss[3:0];
      3'd1:    nib = view.ss[7:4];
      3'd2:    nib = view.mm[3:0];
      3'd3:    nib = view.mm[7:4];
      3'd4:    nib = view.hh[3:0];
      3'd5:    nib = view.hh[7:4];
      default: nib = '0;
    endcase
  end

  always_comb begin
    blank = phase && (view.sel != FLD_NONE) &&
            (view.sel == fld_of_idx(idx));
    lz    = LZ_BLANK && (idx == IDX_LAST) &&
            (nib == 4'd0);
    seg_d = (blank || lz) ? SEG_OFF : font;
    dp_d  = 1'b1;
    if (!blank) begin
      case (idx)
        3'd2, 3'd4: dp_d = 1'b0;
        3'd0:       dp_d = ~view.pm;
        default:    dp_d = 1'b1;
      endcase
    end
    an_d = ~(6'b000001 << idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n <= SEG_OFF;
      dp_n  <= 1'b1;
      an_n  <= 6'h3F;
    end else begin
      seg_n <= seg_d;
      dp_n  <= dp_d;
      an_n  <= an_d;
    end
  end

endmodule

// File: tb/tb_bcd_time_scan_display.sv
// Bench for bcd_time_scan_display: directed scenarios
// plus random traffic against a frame-level model.
module tb_bcd_time_scan_display;

  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FRAME = 6 * RD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] hh = 8'h12;
  logic [7:0] mm = 8'h34;
  logic [7:0] ss = 8'h56;
  logic       pm = 1'b0;
  logic [1:0] blink_sel = 2'd0;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;

  bcd_time_scan_display #(
    .REFRESH_DIV  (RD),
    .BLINK_FRAMES (BF),
    .LZ_BLANK     (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .pm        (pm),
    .blink_sel (blink_sel),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int n = 0;
  string tag = "init";

  logic [7:0] m_hh, m_mm, m_ss;
  logic       m_pm;
  logic [1:0] m_sel;

  logic [6:0] font [10] = '{7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string what,
                       input logic [7:0] got,
                       input logic [7:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s/%s got %h want %h", tag, what, got, want);
    end
  endtask

  task automatic tick();
    logic [6:0] e_seg;
    logic       e_dp;
    logic [5:0] e_an;
    @(posedge clk);
    if (reset) begin
      n = 0;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_an  = 6'h3F;
    end else begin
      int d_idx, f, ph, fld, d;
      int digs [6];
      bit blank;
      if (n % FRAME == 0) begin
        m_hh = hh; m_mm = mm; m_ss = ss;
        m_pm = pm; m_sel = blink_sel;
      end
      d_idx = (n / RD) % 6;
      f     = n / FRAME;
      ph    = (f / BF) % 2;
      digs[0] = m_ss % 16; digs[1] = m_ss / 16;
      digs[2] = m_mm % 16; digs[3] = m_mm / 16;
      digs[4] = m_hh % 16; digs[5] = m_hh / 16;
      d   = digs[d_idx];
      fld = 3 - d_idx / 2;
      blank = (ph == 1) && (m_sel != 0) && (int'(m_sel) == fld);
      if (blank || (d_idx == 5 && d == 0)) e_seg = 7'h7F;
      else if (d > 9) e_seg = 7'h3F;
      else e_seg = font[d];
      if (blank) e_dp = 1'b1;
      else if (d_idx == 2 || d_idx == 4) e_dp = 1'b0;
      else if (d_idx == 0) e_dp = ~m_pm;
      else e_dp = 1'b1;
      e_an = ~(6'(1) << d_idx);
      n++;
    end
    #1;
    check("seg_n", {1'b0, seg_n}, {1'b0, e_seg});
    check("dp_n", {7'b0, dp_n}, {7'b0, e_dp});
    check("an_n", {2'b0, an_n}, {2'b0, e_an});
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  initial begin
    tag = "reset";
    ticks(2);
    reset = 1'b0;

    tag = "base_123456";
    ticks(2 * FRAME);

    tag = "hh09_pm";
    hh = 8'h09; pm = 1'b1;
    ticks(2 * FRAME);

    tag = "ss_mid_frame";
    ticks(3 * RD);
    ss = 8'h57;
    ticks(FRAME + 3 * RD);

    tag = "mm_dash";
    mm = 8'h3C;
    ticks(2 * FRAME);

    tag = "blink_min";
    mm = 8'h34; hh = 8'h12; pm = 1'b0;
    blink_sel = 2'd2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ticks(4 * FRAME + 10);
    blink_sel = 2'd0;
    ticks(2 * FRAME - 10);

    tag = "reset_mid";
    ticks(3 * RD + 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ticks(FRAME);

    tag = "random";
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(5))
          0: hh = bcd($urandom_range(12, 1));
          1: mm = bcd($urandom_range(59));
          2: ss = bcd($urandom_range(59));
          3: pm = 1'($urandom);
          4: blink_sel = 2'($urandom);
          default: mm = 8'($urandom);
        endcase
      end
      reset = ($urandom_range(299) == 0);
      tick();
    end
    reset = 1'b0;
    ticks(FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
